// File: rtl/anim_pkg.sv
// Shared encodings and sizing helpers for the animation frame sequencer.
package anim_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_HOLD     = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Address width covering every pixel of every frame, never below one bit.
  function automatic int unsigned addr_width(input int unsigned frames, input int unsigned w,
                                             input int unsigned h);
    int unsigned aw;
    aw = $clog2(frames * w * h);
    return (aw == 0) ? 1 : aw;
  endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// Frame-step tick generator: cycle counter with speed shift, pause gating and restart clear.
module anim_tick_gen
  import anim_pkg::*;
#(
  parameter int unsigned PERIOD = 33554432
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick_c
);

  localparam int unsigned CW = $clog2(PERIOD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lim_c, last_c;

  // A zero limit at high speed degenerates to a tick every enabled cycle.
  always_comb begin
    lim_c  = CW'(PERIOD) >> speed;
    last_c = (lim_c == '0) ? '0 : lim_c - CW'(1);
    tick_c = en && !clr && (cnt_q >= last_c);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// Animation frame sequencer: play-mode FSM over the frame index plus a registered
// pixel-to-ROM address path for the current frame.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int unsigned FRAMES  = 16,
  parameter int unsigned FRAME_W = 160,
  parameter int unsigned FRAME_H = 120,
  parameter int unsigned PERIOD  = 33554432,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic                                            pause,
  input  logic [1:0]                                      mode,
  input  logic [1:0]                                      speed,
  input  logic [XW-1:0]                                   req_x,
  input  logic [YW-1:0]                                   req_y,
  output logic [addr_width(FRAMES, FRAME_W, FRAME_H)-1:0] rom_addr,
  output logic                                            addr_valid,
  output logic [$clog2(FRAMES)-1:0]                       frame,
  output logic                                            wrap,
  output logic                                            done
);

  localparam int unsigned AW           = addr_width(FRAMES, FRAME_W, FRAME_H);
  localparam int unsigned FW           = $clog2(FRAMES);
  localparam int unsigned FRAME_PIXELS = frame_pixels(FRAME_W, FRAME_H);
  localparam logic [FW-1:0] LAST       = FW'(FRAMES - 1);

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          tick_c;
  logic          tick_en_c;
  logic          in_range_c;
  logic [AW-1:0] base_c, offs_c;

  assign tick_en_c = (state_q == ST_PLAY) && !pause;

  anim_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (tick_en_c),
    .speed (speed),
    .tick_c(tick_c)
  );

  // Next state and frame stepping; dir_q=0 means counting up.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (start) begin
      state_d = ST_PLAY;
      frame_d = '0;
      dir_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick_c) begin
            case (mode)
              MODE_LOOP: begin
                if (frame_q == LAST) begin
                  frame_d = '0;
                  wrap_d  = 1'b1;
                end else begin
                  frame_d = frame_q + FW'(1);
                end
              end
              MODE_ONESHOT: begin
                if (frame_q == LAST || frame_q == LAST - FW'(1)) begin
                  frame_d = LAST;
                  wrap_d  = 1'b1;
                  state_d = ST_DONE;
                end else begin
                  frame_d = frame_q + FW'(1);
                end
              end
              MODE_PINGPONG: begin
                // Turn on arrival at an end frame so it is shown for one period only.
                if (!dir_q) begin
                  if (frame_q == LAST) begin
                    frame_d = frame_q - FW'(1);
                    dir_d   = 1'b1;
                  end else begin
                    frame_d = frame_q + FW'(1);
                    if (frame_q == LAST - FW'(1)) begin
                      dir_d  = 1'b1;
                      wrap_d = 1'b1;
                    end
                  end
                end else begin
                  if (frame_q == '0) begin
                    frame_d = frame_q + FW'(1);
                    dir_d   = 1'b0;
                  end else begin
                    frame_d = frame_q - FW'(1);
                    if (frame_q == FW'(1)) begin
                      dir_d  = 1'b0;
                      wrap_d = 1'b1;
                    end
                  end
                end
              end
              default: ;
            endcase
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_PLAY;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  // Out-of-range requests fall back to the frame base address.
  always_comb begin
    in_range_c = (32'(req_x) < FRAME_W) && (32'(req_y) < FRAME_H);
    base_c     = AW'(frame_q) * AW'(FRAME_PIXELS);
    offs_c     = AW'(req_y) * AW'(FRAME_W) + AW'(req_x);
    addr_d     = in_range_c ? base_c + offs_c : base_c;
    valid_d    = in_range_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign rom_addr   = addr_q;
  assign addr_valid = valid_q;
  assign frame      = frame_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: frame sequences per play mode, pause, speed and address path.
module tb_anim_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, pause_a = 1'b0;
  logic [1:0] mode_a = 2'd0, speed_a = 2'd0;
  logic [7:0] req_x_a = 8'd0, req_y_a = 8'd0;
  logic [4:0] rom_addr_a;
  logic       addr_valid_a, wrap_a, done_a;
  logic [1:0] frame_a;

  logic       start_b = 1'b0, pause_b = 1'b0;
  logic [1:0] mode_b = 2'd0, speed_b = 2'd0;
  logic [7:0] req_x_b = 8'd0, req_y_b = 8'd0;
  logic [4:0] rom_addr_b;
  logic       addr_valid_b, wrap_b, done_b;
  logic [1:0] frame_b;

  anim_sequencer #(.FRAMES(4), .FRAME_W(4), .FRAME_H(2), .PERIOD(3), .XW(8), .YW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pause(pause_a), .mode(mode_a), .speed(speed_a),
    .req_x(req_x_a), .req_y(req_y_a), .rom_addr(rom_addr_a), .addr_valid(addr_valid_a),
    .frame(frame_a), .wrap(wrap_a), .done(done_a)
  );

  anim_sequencer #(.FRAMES(4), .FRAME_W(4), .FRAME_H(2), .PERIOD(8), .XW(8), .YW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pause(pause_b), .mode(mode_b), .speed(speed_b),
    .req_x(req_x_b), .req_y(req_y_b), .rom_addr(rom_addr_b), .addr_valid(addr_valid_b),
    .frame(frame_b), .wrap(wrap_b), .done(done_b)
  );

  typedef struct {
    logic [1:0] frame;
    logic       wrap;
    logic       done;
  } fexp_t;

  typedef struct {
    logic [4:0] addr;
    logic       valid;
  } aexp_t;

  fexp_t fq[$];
  aexp_t aq[$];
  int errors = 0;
  int checks = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (frame_a !== 2'd0 || wrap_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: frame=%0d wrap=%0b done=%0b, want 0 0 0", frame_a, wrap_a, done_a);
    end
    checks++;
    if (rom_addr_a !== 5'd0 || addr_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_addr: addr=%0d valid=%0b, want 0 0", rom_addr_a, addr_valid_a);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (frame_a !== 2'd0) begin
        errors++;
        $display("FAIL idle_frame: frame=%0d, want 0", frame_a);
      end
    end
  endtask

  task automatic test_loop();
    fexp_t e;
    mode_a = 2'd0; speed_a = 2'd0; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    for (int k = 0; k < 14; k++) begin
      e.frame = 2'((k / 3) % 4); e.wrap = (k == 12); e.done = 1'b0;
      fq.push_back(e);
    end
    while (fq.size() > 0) begin
      e = fq.pop_front();
      checks++;
      if (frame_a !== e.frame || wrap_a !== e.wrap || done_a !== e.done) begin
        errors++;
        $display("FAIL loop: got f=%0d w=%0b d=%0b, want f=%0d w=%0b d=%0b",
                 frame_a, wrap_a, done_a, e.frame, e.wrap, e.done);
      end
      cyc();
    end
  endtask

  task automatic test_oneshot();
    fexp_t e;
    mode_a = 2'd1; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      e.frame = (k < 9) ? 2'(k / 3) : 2'd3; e.wrap = (k == 9); e.done = (k >= 9);
      fq.push_back(e);
    end
    while (fq.size() > 0) begin
      e = fq.pop_front();
      checks++;
      if (frame_a !== e.frame || wrap_a !== e.wrap || done_a !== e.done) begin
        errors++;
        $display("FAIL oneshot: got f=%0d w=%0b d=%0b, want f=%0d w=%0b d=%0b",
                 frame_a, wrap_a, done_a, e.frame, e.wrap, e.done);
      end
      cyc();
    end
    // Address path still live in DONE (frame 3): 24 + 1*4 + 1
    req_x_a = 8'd1; req_y_a = 8'd1;
    cyc();
    checks++;
    if (rom_addr_a !== 5'd29 || addr_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL done_addr: addr=%0d valid=%0b, want 29 1", rom_addr_a, addr_valid_a);
    end
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    checks++;
    if (frame_a !== 2'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_restart: frame=%0d done=%0b, want 0 0", frame_a, done_a);
    end
  endtask

  task automatic test_pingpong();
    fexp_t e;
    int seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    mode_a = 2'd2; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    for (int k = 0; k < 24; k++) begin
      e.frame = 2'(seq[k / 3]); e.wrap = (k == 9 || k == 18); e.done = 1'b0;
      fq.push_back(e);
    end
    while (fq.size() > 0) begin
      e = fq.pop_front();
      checks++;
      if (frame_a !== e.frame || wrap_a !== e.wrap || done_a !== e.done) begin
        errors++;
        $display("FAIL pingpong: got f=%0d w=%0b d=%0b, want f=%0d w=%0b d=%0b",
                 frame_a, wrap_a, done_a, e.frame, e.wrap, e.done);
      end
      cyc();
    end
  endtask

  task automatic test_speed_change();
    fexp_t e;
    mode_a = 2'd0; speed_a = 2'd0; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    cyc();
    // counter now 1; new limit 3>>1=1 makes it already terminal
    speed_a = 2'd1;
    for (int k = 1; k < 6; k++) begin
      e.frame = (k == 1) ? 2'd0 : 2'((k - 1) % 4); e.wrap = (k == 5); e.done = 1'b0;
      fq.push_back(e);
    end
    while (fq.size() > 0) begin
      e = fq.pop_front();
      checks++;
      if (frame_a !== e.frame || wrap_a !== e.wrap) begin
        errors++;
        $display("FAIL speed_change: got f=%0d w=%0b, want f=%0d w=%0b",
                 frame_a, wrap_a, e.frame, e.wrap);
      end
      cyc();
    end
    speed_a = 2'd0;
  endtask

  task automatic test_pause();
    fexp_t e;
    int k;
    mode_b = 2'd0; speed_b = 2'd2; start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int i = 0; i < 13; i++) begin
      e.frame = (i < 2) ? 2'd0 : (i < 10) ? 2'd1 : (i < 12) ? 2'd2 : 2'd3;
      e.wrap = 1'b0; e.done = 1'b0;
      fq.push_back(e);
    end
    k = 0;
    while (fq.size() > 0) begin
      e = fq.pop_front();
      checks++;
      if (frame_b !== e.frame || wrap_b !== e.wrap || done_b !== e.done) begin
        errors++;
        $display("FAIL pause k=%0d: got f=%0d w=%0b d=%0b, want f=%0d w=%0b d=%0b",
                 k, frame_b, wrap_b, done_b, e.frame, e.wrap, e.done);
      end
      pause_b = (k >= 3 && k <= 7);
      k++;
      cyc();
    end
    pause_b = 1'b1; start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    checks++;
    if (frame_b !== 2'd0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL start_over_pause: frame=%0d done=%0b, want 0 0", frame_b, done_b);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (frame_b !== 2'd0) begin
        errors++;
        $display("FAIL paused_hold: frame=%0d, want 0", frame_b);
      end
    end
    pause_b = 1'b0;
    cyc();
    cyc();
    checks++;
    if (frame_b !== 2'd0) begin
      errors++;
      $display("FAIL resume_early: frame=%0d, want 0", frame_b);
    end
    cyc();
    checks++;
    if (frame_b !== 2'd1) begin
      errors++;
      $display("FAIL resume_step: frame=%0d, want 1", frame_b);
    end
  endtask

  task automatic test_addr();
    aexp_t e;
    logic [7:0] xs[6] = '{8'd3, 8'd4, 8'd0, 8'd3, 8'd255, 8'd2};
    logic [7:0] ys[6] = '{8'd1, 8'd0, 8'd0, 8'd2, 8'd255, 8'd1};
    mode_a = 2'd0; speed_a = 2'd0; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    mode_a = 2'd3;
    checks++;
    if (frame_a !== 2'd2) begin
      errors++;
      $display("FAIL addr_setup: frame=%0d, want 2", frame_a);
    end
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (frame_a !== 2'd2 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL hold: frame=%0d wrap=%0b, want 2 0", frame_a, wrap_a);
    end
    for (int i = 0; i < 6; i++) begin
      req_x_a = xs[i]; req_y_a = ys[i];
      e.valid = (xs[i] < 8'd4) && (ys[i] < 8'd2);
      e.addr  = e.valid ? 5'(16 + 4 * int'(ys[i]) + int'(xs[i])) : 5'd16;
      aq.push_back(e);
      cyc();
      e = aq.pop_front();
      checks++;
      if (rom_addr_a !== e.addr || addr_valid_a !== e.valid) begin
        errors++;
        $display("FAIL addr x=%0d y=%0d: got addr=%0d valid=%0b, want addr=%0d valid=%0b",
                 xs[i], ys[i], rom_addr_a, addr_valid_a, e.addr, e.valid);
      end
    end
  endtask

  task automatic test_async_reset();
    req_x_a = 8'd3; req_y_a = 8'd1;
    cyc();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (frame_a !== 2'd0 || wrap_a !== 1'b0 || done_a !== 1'b0 ||
        rom_addr_a !== 5'd0 || addr_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: f=%0d w=%0b d=%0b addr=%0d v=%0b, want all 0",
               frame_a, wrap_a, done_a, rom_addr_a, addr_valid_a);
    end
    #3;
    rst_n = 1'b1;
    mode_a = 2'd0;
    cyc();
    checks++;
    if (rom_addr_a !== 5'd7 || addr_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL idle_addr: addr=%0d valid=%0b, want 7 1", rom_addr_a, addr_valid_a);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (frame_a !== 2'd0 || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: frame=%0d wrap=%0b, want 0 0", frame_a, wrap_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_pingpong();
    test_speed_change();
    test_pause();
    test_addr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
Parametrised animation frame sequencer for the sprite/animation path of the VGA display pipeline. It replaces a divided-clock step counter with a single-clock design: a clock-enable frame tick, configurable frame count, and a play mode of loop, one-shot, ping-pong or hold. It also converts pixel (x,y) requests into a registered ROM address inside the current frame. Output goes straight to the per-animation frame memory.

Parameters:
FRAMES, 16, number of animation frames (>=2)
FRAME_W, 160, frame width in pixels
FRAME_H, 120, frame height in pixels
PERIOD, 33554432, base clk cycles per frame step (>=2)
XW, 8, width of x request
YW, 8, width of y request

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: restart sequence from frame 0 and play
pause  in  1  level: freeze tick counter and frame index while high
mode  in  2  0=loop, 1=one-shot, 2=ping-pong, 3=hold
speed  in  2  frame period = PERIOD >> speed
req_x  in  XW  pixel x request
req_y  in  YW  pixel y request
rom_addr  out  clog2(FRAMES*FRAME_W*FRAME_H)  frame*FRAME_W*FRAME_H + y*FRAME_W + x
addr_valid  out  1  request in range (x<FRAME_W, y<FRAME_H)
frame  out  clog2(FRAMES)  current frame index
wrap  out  1  one-cycle pulse when sequence boundary reached
done  out  1  high in DONE state

Behaviour:
- Reset (rst_n low, async): state IDLE; frame=0; tick counter=0; dir=up; rom_addr=0; addr_valid=0; wrap=0; done=0.
- States: IDLE, PLAY, PAUSED, DONE.
  - IDLE --start--> PLAY.
  - PLAY --pause--> PAUSED; PAUSED --!pause--> PLAY. The counter value is retained across the pause.
  - PLAY --one-shot reaches last frame--> DONE.
  - DONE --start--> PLAY.
  - start from any state: frame=0, counter=0, dir=up, done=0, next state PLAY.
  - start has priority over pause in the same cycle.
- Tick: counter counts 0..(PERIOD>>speed)-1 in PLAY only; tick asserts on the terminal count and the counter returns to 0.
  - A speed change mid-count takes effect immediately. If the counter is already >= the new limit, tick on the next cycle.
- Frame update on tick:
  - loop: frame+1; FRAMES-1 -> 0 with wrap=1.
  - one-shot: frame+1; on reaching FRAMES-1, wrap=1 and go to DONE. frame stays FRAMES-1.
  - ping-pong: up until FRAMES-1, then down; down until 0, then up. wrap=1 at each turn. End frames show for one period only, never twice.
  - hold: frame unchanged, no wrap.
  - A mode change takes effect on the next tick. If switching to ping-pong, dir is kept.
- wrap: registered, exactly one cycle, coincident with the frame update.
- Address path: one-cycle latency from req_x/req_y to rom_addr/addr_valid.
  - Uses the frame value as registered at the request cycle.
  - If out of range: addr_valid=0 and rom_addr=frame*FRAME_W*FRAME_H (frame base).
  - Products are constant-multiplies sized to the full address width; no truncation.
- Address path runs in every state, including IDLE and DONE.

Decomposition:
- Shared package anim_pkg holds:
  - mode encodings MODE_LOOP/MODE_ONESHOT/MODE_PINGPONG/MODE_HOLD;
  - state encodings;
  - FRAME_PIXELS = FRAME_W*FRAME_H;
  - address-width function.
- One sub-module anim_tick_gen: counter, speed shift, pause gating, start clear; emits tick. The rest stays in anim_sequencer.

Test Plan:
(All scenarios use FRAMES=4, FRAME_W=4, FRAME_H=2, PERIOD=3 unless stated.)
1. Reset then start, mode=0, speed=0 -> frame 0,1,2,3,0 at ticks every 3 cycles; wrap pulses for 1 cycle at 3->0; done stays 0.
2. mode=1, start -> frame reaches 3, wrap=1 once, done=1, frame holds 3 for 20 cycles; a second start -> frame=0, done=0 next cycle.
3. mode=2 -> frame sequence 0,1,2,3,2,1,0,1, with wrap at 3 and at 0; no frame repeated.
4. PERIOD=8, speed=2: ticks every 2 cycles. pause high for 5 cycles mid-count -> frame and counter frozen; resume completes the remaining count. start with pause high -> PLAY, frame=0.
5. frame=2; req (x=3,y=1) -> next cycle rom_addr=2*8+1*4+3=23, addr_valid=1. req (x=4,y=0) -> addr_valid=0, rom_addr=16.
6. Assert rst_n low mid-PLAY between clock edges -> outputs zero immediately, state IDLE; no ticks until start.
